// File: rtl/alu_issue_stage_if.sv
// alu_issue_stage_if: request, ALU and writeback signals of the ALU issue stage
// Ports: flush, in_* request handshake, alu_* ALU drive/return, out_* writeback handshake.
// master = environment side, slave = issue stage side.
interface alu_issue_stage_if #(
  parameter int TAG_W = 5,
  parameter int DATA_W = 64
);
  logic flush;
  logic in_valid;
  logic in_ready;
  logic [1:0] in_op;
  logic [TAG_W-1:0] in_rs1_tag;
  logic [TAG_W-1:0] in_rs2_tag;
  logic [DATA_W-1:0] in_rs1_val;
  logic [DATA_W-1:0] in_rs2_val;
  logic [TAG_W-1:0] in_rd_tag;
  logic [1:0] alu_op;
  logic [DATA_W-1:0] alu_arg1;
  logic [DATA_W-1:0] alu_arg2;
  logic [DATA_W-1:0] alu_result;
  logic out_valid;
  logic out_ready;
  logic [DATA_W-1:0] out_result;
  logic [TAG_W-1:0] out_rd_tag;
  modport master (
    output flush, in_valid, in_op, in_rs1_tag, in_rs2_tag, in_rs1_val, in_rs2_val, in_rd_tag,
    output alu_result, out_ready,
    input in_ready, alu_op, alu_arg1, alu_arg2, out_valid, out_result, out_rd_tag
  );
  modport slave (
    input flush, in_valid, in_op, in_rs1_tag, in_rs2_tag, in_rs1_val, in_rs2_val, in_rd_tag,
    input alu_result, out_ready,
    output in_ready, alu_op, alu_arg1, alu_arg2, out_valid, out_result, out_rd_tag
  );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: operand/issue stage A and result stage B in front of a 64-bit ALU
// Ports: clk, rst_n (async, active low), io (alu_issue_stage_if.slave) carrying
// flush, the in_* request handshake, the alu_* ALU interface and the out_* writeback handshake.
// ALU_ISSUE_FWD_EN: defined = bypass from A/B into the operands; undefined = interlock on A/B hazards.
module alu_issue_stage #(
  parameter int TAG_W = 5,
  parameter int DATA_W = 64
) (
  input logic clk,
  input logic rst_n,
  alu_issue_stage_if.slave io
);
  logic a_valid, b_valid, adv_a, adv_b, acc;
  logic [TAG_W-1:0] a_rd, b_rd;
  logic [1:0] op_q;
  logic [DATA_W-1:0] arg1_q, arg2_q, res_q, src1, src2;
  assign adv_b = !b_valid || io.out_ready;
  assign adv_a = !a_valid || adv_b;
`ifdef ALU_ISSUE_FWD_EN
  // A holds the younger producer, so it wins over B
  assign src1 = io.in_rs1_tag == '0 ? '0 :
                a_valid && io.in_rs1_tag == a_rd ? io.alu_result :
                b_valid && io.in_rs1_tag == b_rd ? res_q : io.in_rs1_val;
  assign src2 = io.in_rs2_tag == '0 ? '0 :
                a_valid && io.in_rs2_tag == a_rd ? io.alu_result :
                b_valid && io.in_rs2_tag == b_rd ? res_q : io.in_rs2_val;
  assign io.in_ready = adv_a;
`else
  logic haz1, haz2;
  // hold a consumer until its producer has committed out of B
  assign haz1 = io.in_rs1_tag != '0 &&
                ((a_valid && io.in_rs1_tag == a_rd) || (b_valid && io.in_rs1_tag == b_rd));
  assign haz2 = io.in_rs2_tag != '0 &&
                ((a_valid && io.in_rs2_tag == a_rd) || (b_valid && io.in_rs2_tag == b_rd));
  assign src1 = io.in_rs1_tag == '0 ? '0 : io.in_rs1_val;
  assign src2 = io.in_rs2_tag == '0 ? '0 : io.in_rs2_val;
  assign io.in_ready = adv_a && !haz1 && !haz2;
`endif
  assign acc = io.in_valid && io.in_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid <= 1'b0;
      b_valid <= 1'b0;
      a_rd <= '0;
      b_rd <= '0;
      op_q <= '0;
      arg1_q <= '0;
      arg2_q <= '0;
      res_q <= '0;
    end else if (io.flush) begin
      a_valid <= 1'b0;
      b_valid <= 1'b0;
    end else begin
      if (adv_a) begin
        a_valid <= acc;
        if (acc) begin
          op_q <= io.in_op;
          arg1_q <= src1;
          arg2_q <= src2;
          a_rd <= io.in_rd_tag;
        end
      end
      if (adv_b) begin
        b_valid <= a_valid;
        if (a_valid) begin
          res_q <= io.alu_result;
          b_rd <= a_rd;
        end
      end
    end
  end
  assign io.alu_op = op_q;
  assign io.alu_arg1 = arg1_q;
  assign io.alu_arg2 = arg2_q;
  assign io.out_valid = b_valid;
  assign io.out_result = res_q;
  assign io.out_rd_tag = b_rd;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed checks of alu_issue_stage with a behavioural ALU and register file
module tb_alu_issue_stage;
  localparam bit FWD =
`ifdef ALU_ISSUE_FWD_EN
    1'b1;
`else
    1'b0;
`endif
  localparam logic [1:0] AND_OP = 2'd0, OR_OP = 2'd1, ADD_OP = 2'd2, SUB_OP = 2'd3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int pass_n = 0;
  int tot_n = 0;
  int stall;
  logic [63:0] rf [32];
  logic [68:0] exp_q [$];
  alu_issue_stage_if #(.TAG_W(5), .DATA_W(64)) io ();
  alu_issue_stage #(.TAG_W(5), .DATA_W(64)) dut (.clk(clk), .rst_n(rst_n), .io(io));
  always #5 clk = ~clk;
  assign io.alu_result = io.alu_op == AND_OP ? io.alu_arg1 & io.alu_arg2 :
                         io.alu_op == OR_OP ? io.alu_arg1 | io.alu_arg2 :
                         io.alu_op == ADD_OP ? io.alu_arg1 + io.alu_arg2 : io.alu_arg1 - io.alu_arg2;
  task automatic chk(input string t, input logic [63:0] got, input logic [63:0] exp);
    tot_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", t, got, exp);
  endtask
  always @(negedge clk) begin
    if (rst_n && io.out_valid && io.out_ready) begin
      logic [68:0] e;
      bit real_e;
      real_e = exp_q.size() != 0;
      e = real_e ? exp_q.pop_front() : '1;
      chk("wb_result", io.out_result, e[63:0]);
      chk("wb_tag", 64'(io.out_rd_tag), 64'(e[68:64]));
      if (real_e && e[68:64] != 5'd0) rf[e[68:64]] = e[63:0];
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic present(input logic [1:0] op, input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
    io.in_valid = 1'b1;
    io.in_op = op;
    io.in_rs1_tag = r1;
    io.in_rs2_tag = r2;
    io.in_rd_tag = rd;
    io.in_rs1_val = rf[r1];
    io.in_rs2_val = rf[r2];
  endtask
  task automatic issue(input logic [1:0] op, input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                       input logic [63:0] e, input bit keep);
    bit ok;
    ok = 1'b0;
    stall = 0;
    if (keep) exp_q.push_back({rd, e});
    for (int n = 0; n < 20 && !ok; n++) begin
      present(op, r1, r2, rd);
      @(negedge clk);
      ok = io.in_ready;
      if (!ok) stall++;
      tick();
    end
    io.in_valid = 1'b0;
    chk("accepted", 64'(ok), 64'd1);
  endtask
  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 64'd0;
    rf[0] = 64'hFFFF;
    rf[1] = 64'd5;
    rf[2] = 64'd7;
    rf[5] = 64'd10;
    rf[6] = 64'd3;
    rf[7] = 64'd1;
    rf[9] = 64'd20;
    rf[10] = 64'd5;
    rf[14] = 64'd1;
    rf[15] = 64'd2;
    rf[21] = 64'hFFFF_FFFF_FFFF_FFFF;
    rf[22] = 64'd1;
    rf[26] = 64'd100;
    rf[27] = 64'd200;
    io.flush = 1'b0;
    io.out_ready = 1'b1;
    present(ADD_OP, 5'd0, 5'd0, 5'd0);
    io.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(io.in_ready), 64'd1);
    chk("rst_out_valid", 64'(io.out_valid), 64'd0);
    chk("rst_alu_op", 64'(io.alu_op), 64'd0);
    chk("rst_arg1", io.alu_arg1, 64'd0);
    chk("rst_arg2", io.alu_arg2, 64'd0);
    chk("rst_result", io.out_result, 64'd0);
    chk("rst_rd_tag", 64'(io.out_rd_tag), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    issue(ADD_OP, 5'd1, 5'd2, 5'd3, 64'd12, 1'b1);
    chk("lat_a_valid_n1", 64'(io.out_valid), 64'd0);
    chk("lat_arg1", io.alu_arg1, 64'd5);
    chk("lat_arg2", io.alu_arg2, 64'd7);
    chk("lat_op", 64'(io.alu_op), 64'(ADD_OP));
    tick();
    chk("lat_out_valid_n2", 64'(io.out_valid), 64'd1);
    chk("lat_result", io.out_result, 64'd12);
    chk("lat_rd_tag", 64'(io.out_rd_tag), 64'd3);
    tick();
    chk("lat_one_cycle", 64'(io.out_valid), 64'd0);
    issue(SUB_OP, 5'd5, 5'd6, 5'd4, 64'd7, 1'b1);
    issue(ADD_OP, 5'd4, 5'd7, 5'd8, 64'd8, 1'b1);
    chk("dep_a_stall", 64'(stall), FWD ? 64'd0 : 64'd2);
    repeat (3) tick();
    issue(ADD_OP, 5'd9, 5'd10, 5'd11, 64'd25, 1'b1);
    tick();
    issue(AND_OP, 5'd11, 5'd11, 5'd12, 64'd25, 1'b1);
    chk("dep_b_stall", 64'(stall), FWD ? 64'd0 : 64'd1);
    repeat (3) tick();
    issue(ADD_OP, 5'd14, 5'd15, 5'd13, 64'd3, 1'b1);
    issue(ADD_OP, 5'd14, 5'd14, 5'd13, 64'd2, 1'b1);
    issue(SUB_OP, 5'd13, 5'd14, 5'd16, 64'd1, 1'b1);
    chk("prio_stall", 64'(stall), FWD ? 64'd0 : 64'd2);
    repeat (3) tick();
    io.out_ready = 1'b0;
    issue(ADD_OP, 5'd1, 5'd2, 5'd17, 64'd12, 1'b1);
    issue(OR_OP, 5'd1, 5'd2, 5'd18, 64'd7, 1'b1);
    present(AND_OP, 5'd1, 5'd2, 5'd19);
    exp_q.push_back({5'd19, 64'd5});
    repeat (4) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(io.in_ready), 64'd0);
      chk("bp_out_valid", 64'(io.out_valid), 64'd1);
      chk("bp_result", io.out_result, 64'd12);
      chk("bp_alu_op", 64'(io.alu_op), 64'(OR_OP));
      chk("bp_arg1", io.alu_arg1, 64'd5);
      tick();
    end
    io.out_ready = 1'b1;
    begin
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 20 && !ok; n++) begin
        @(negedge clk);
        ok = io.in_ready;
        tick();
      end
      chk("bp_release", 64'(ok), 64'd1);
    end
    io.in_valid = 1'b0;
    repeat (4) tick();
    issue(ADD_OP, 5'd1, 5'd2, 5'd0, 64'd12, 1'b1);
    issue(OR_OP, 5'd0, 5'd2, 5'd20, 64'd7, 1'b1);
    chk("zero_arg1", io.alu_arg1, 64'd0);
    chk("zero_stall", 64'(stall), 64'd0);
    repeat (3) tick();
    issue(ADD_OP, 5'd21, 5'd22, 5'd24, 64'd0, 1'b1);
    issue(SUB_OP, 5'd23, 5'd22, 5'd25, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    repeat (3) tick();
    io.out_ready = 1'b0;
    issue(ADD_OP, 5'd1, 5'd2, 5'd26, 64'd0, 1'b0);
    issue(OR_OP, 5'd1, 5'd2, 5'd27, 64'd0, 1'b0);
    present(ADD_OP, 5'd1, 5'd2, 5'd28);
    io.flush = 1'b1;
    @(negedge clk);
    chk("fl_pre_valid", 64'(io.out_valid), 64'd1);
    tick();
    io.flush = 1'b0;
    io.in_valid = 1'b0;
    chk("fl_out_valid", 64'(io.out_valid), 64'd0);
    io.out_ready = 1'b1;
    issue(ADD_OP, 5'd26, 5'd27, 5'd29, 64'd300, 1'b1);
    chk("fl_stall", 64'(stall), 64'd0);
    repeat (4) tick();
    io.out_ready = 1'b0;
    issue(ADD_OP, 5'd1, 5'd2, 5'd30, 64'd0, 1'b0);
    issue(ADD_OP, 5'd1, 5'd2, 5'd31, 64'd0, 1'b0);
    tick();
    @(negedge clk);
    chk("rs_pre_valid", 64'(io.out_valid), 64'd1);
    chk("rs_pre_ready", 64'(io.in_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_out_valid", 64'(io.out_valid), 64'd0);
    chk("rs_in_ready", 64'(io.in_ready), 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    io.out_ready = 1'b1;
    issue(SUB_OP, 5'd2, 5'd1, 5'd3, 64'd2, 1'b1);
    repeat (4) tick();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Pipeline stage directly upstream of the 64-bit ALU (ops AND/OR/ADD/SUB, 2-bit op code).
- Accepts decoded ALU requests over a valid/ready handshake.
- Resolves operands through a bypass network.
- Drives the ALU combinational inputs from an operand register, then captures the ALU result into a result register for writeback.
- Two register stages: A (operand/issue) and B (result). Throughput is 1 op/cycle.

Parameters:
TAG_W, 5, register tag width; tag 0 is the hardwired zero register.
DATA_W, 64, operand/result width; must match the ALU (64).

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous; discards stages A and B
in_valid  in  1  request valid
in_ready  out  1  stage can accept request this cycle
in_op  in  2  00 AND, 01 OR, 10 ADD, 11 SUB
in_rs1_tag  in  TAG_W  source 1 register tag
in_rs2_tag  in  TAG_W  source 2 register tag
in_rs1_val  in  DATA_W  register-file value for rs1
in_rs2_val  in  DATA_W  register-file value for rs2
in_rd_tag  in  TAG_W  destination tag
alu_op  out  2  to ALU op (registered, stage A)
alu_arg1  out  DATA_W  to ALU arg1 (stage A)
alu_arg2  out  DATA_W  to ALU arg2 (stage A)
alu_result  in  DATA_W  from ALU result (combinational from alu_* outputs)
out_valid  out  1  stage B holds a result
out_ready  in  1  writeback accepts result
out_result  out  DATA_W  stage B result
out_rd_tag  out  TAG_W  stage B destination tag

Behaviour:
- Reset (rst_n low, async): all valid bits cleared; alu_op, alu_arg1, alu_arg2, out_result, out_rd_tag, and the A/B rd tags all set to 0. Outputs: out_valid=0, in_ready=1.
- B handshake: adv_b = !B_valid | out_ready.
- A advance: adv_a = !A_valid | adv_b.
- in_ready = adv_a.
- Accept occurs when in_valid & in_ready.
- Latency: accept at edge N -> A_valid from N+1 (ALU sees operands) -> out_valid from N+2. Back-to-back accepts allowed.
- On the edge with adv_a: A loads the accepted request, or A_valid<=0 if nothing is accepted. B loads alu_result and the A rd tag when A_valid, else B_valid<=0, provided adv_b.
- When out_valid=1 and out_ready=0: B, A and all alu_* outputs hold stable; in_ready=0 if A_valid.
- Operand bypass, evaluated per source independently:
  - Tag 0 always yields 0, regardless of in_rsX_val.
  - Else, if A_valid and tag equals A rd tag, use alu_result. The younger op has priority.
  - Else, if B_valid and tag equals B rd tag, use out_result.
  - Else use in_rsX_val.
- Writeback commits to the register file at the out handshake edge. B stays valid through that edge, so no hazard window exists.
- Arithmetic wraps modulo 2^64; no flags are produced.
- flush=1 at an edge: A_valid<=0 and B_valid<=0; an input presented that cycle is dropped. Flush overrides accept.
- Data registers need not clear on flush; alu_* outputs may retain stale values while A is invalid.
- Reset mid-operation: all in-flight ops are lost immediately; no output pulse.

Optional Feature:
ALU_ISSUE_FWD_EN.
- Defined: bypass network as described above.
- Undefined: no bypass muxes; operands come only from in_rsX_val (tag 0 still yields 0). Interlock applies instead: in_ready=0 whenever a nonzero in_rs1_tag/in_rs2_tag matches the rd tag of a valid A or valid B, plus the normal adv_a condition.
- Without the feature, a dependent op issues the cycle after the producer leaves B.

Test Plan:
- Reset then single op: ADD rs1_val=5, rs2_val=7, rd=3; out_ready=1 -> out_valid one cycle at N+2, out_result=12, out_rd_tag=3.
- Back-to-back dependency: SUB 10-3 ->rd=4, next cycle ADD rs1=4 (stale rs1_val=0), rs2_val=1 -> second out_result=8. With the feature undefined: in_ready=0 for 2 cycles, result 8 with the correct regfile value.
- Backpressure: 3 ops issued, out_ready=0 for 4 cycles -> in_ready=0 after A fills; out_result/alu_* held stable; release gives all 3 results in order, no loss or duplication.
- Zero-register: OR rs1=0 (rs1_val=0xFFFF), rd=0 in flight earlier -> arg1=0, never forwarded.
- Wrap-around: ADD 0xFFFF_FFFF_FFFF_FFFF+1 -> 0; SUB 0-1 -> 0xFFFF_FFFF_FFFF_FFFF.
- Flush/reset mid-flight: flush with A and B valid -> out_valid=0 next cycle, subsequent op unaffected by bypass. Assert rst_n=0 mid-stall -> out_valid=0 immediately, in_ready=1.
